// File: rtl/shft_seq_pkg.sv
// Shared shifter encodings: ALU op codes, 3-bit shift op field, sequencer states.
package shft_seq_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned OP_W   = 3;

   // ALU op code field is AOP_IDX+1 bits wide
   localparam int unsigned AOP_IDX = 4;

   localparam logic [AOP_IDX:0] AOP_RL  = 5'h10;
   localparam logic [AOP_IDX:0] AOP_RLC = 5'h11;
   localparam logic [AOP_IDX:0] AOP_RR  = 5'h12;
   localparam logic [AOP_IDX:0] AOP_RRC = 5'h13;
   localparam logic [AOP_IDX:0] AOP_SLA = 5'h14;
   localparam logic [AOP_IDX:0] AOP_SLL = 5'h15;
   localparam logic [AOP_IDX:0] AOP_SRA = 5'h16;
   localparam logic [AOP_IDX:0] AOP_SRL = 5'h17;

   typedef enum logic [OP_W-1:0] {
      OP_RL  = 3'd0,
      OP_RLC = 3'd1,
      OP_RR  = 3'd2,
      OP_RRC = 3'd3,
      OP_SLA = 3'd4,
      OP_SLL = 3'd5,
      OP_SRA = 3'd6,
      OP_SRL = 3'd7
   } shft_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } seq_state_e;

   // Translate the compact shift op field into the ALU op code
   function automatic logic [AOP_IDX:0] map_op(input shft_op_e op);
      logic [AOP_IDX:0] aop;
      aop = AOP_RL;
      case (op)
         OP_RL:   aop = AOP_RL;
         OP_RLC:  aop = AOP_RLC;
         OP_RR:   aop = AOP_RR;
         OP_RRC:  aop = AOP_RRC;
         OP_SLA:  aop = AOP_SLA;
         OP_SLL:  aop = AOP_SLL;
         OP_SRA:  aop = AOP_SRA;
         OP_SRL:  aop = AOP_SRL;
         default: aop = AOP_RL;
      endcase
      return aop;
   endfunction

endpackage

// File: rtl/shft_seq_alu_shft.sv
// Single-bit shift/rotate datapath of the ALU; purely combinational.
module alu_shft
   import shft_seq_pkg::*;
(
   input  logic [DATA_W-1:0] alub_in,
   input  logic              carry_bit,
   input  logic [AOP_IDX:0]  aluop_reg,
   output logic [DATA_W-1:0] shft_out,
   output logic              shft_c
);

   // One shift step; non-shift op codes pass the operand and carry through
   always_comb begin
      shft_out = alub_in;
      shft_c   = carry_bit;
      case (aluop_reg)
         AOP_RL: begin
            shft_out = {alub_in[6:0], carry_bit};
            shft_c   = alub_in[7];
         end
         AOP_RLC: begin
            shft_out = {alub_in[6:0], alub_in[7]};
            shft_c   = alub_in[7];
         end
         AOP_RR: begin
            shft_out = {carry_bit, alub_in[7:1]};
            shft_c   = alub_in[0];
         end
         AOP_RRC: begin
            shft_out = {alub_in[0], alub_in[7:1]};
            shft_c   = alub_in[0];
         end
         AOP_SLA: begin
            shft_out = {alub_in[6:0], 1'b0};
            shft_c   = alub_in[7];
         end
         AOP_SLL: begin
            shft_out = {alub_in[6:0], 1'b1};
            shft_c   = alub_in[7];
         end
         AOP_SRA: begin
            shft_out = {alub_in[7], alub_in[7:1]};
            shft_c   = alub_in[0];
         end
         AOP_SRL: begin
            shft_out = {1'b0, alub_in[7:1]};
            shft_c   = alub_in[0];
         end
         default: begin
            shft_out = alub_in;
            shft_c   = carry_bit;
         end
      endcase
   end

endmodule

// File: rtl/shft_seq.sv
// Multi-step shift/rotate sequencer: repeats one shift op 1..8 times through alu_shft.
module shft_seq
   import shft_seq_pkg::*;
(
   input  logic              clkc,
   input  logic              resetb,
   input  logic              start,
   input  logic              abort,
   input  logic [OP_W-1:0]   op_in,
   input  logic [CNT_W-1:0]  cnt_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              carry_in,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result_out,
   output logic              carry_out,
   output logic              sign_out,
   output logic              zero_out,
   output logic              parity_out
);

   seq_state_e        state;
   shft_op_e          op_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [DATA_W-1:0] data_reg;
   logic              c_reg;

   logic [AOP_IDX:0]  aop_c;
   logic [DATA_W-1:0] shft_out;
   logic              shft_c;

   assign aop_c = map_op(op_reg);

   alu_shft u_shft (
      .alub_in   (data_reg),
      .carry_bit (c_reg),
      .aluop_reg (aop_c),
      .shft_out  (shft_out),
      .shft_c    (shft_c)
   );

   // Sequencer FSM with operand/carry registers; busy and done are registered
   always_ff @(posedge clkc or negedge resetb) begin
      if (!resetb) begin
         state    <= ST_IDLE;
         op_reg   <= OP_RL;
         cnt_reg  <= '0;
         data_reg <= '0;
         c_reg    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               // abort outranks start so a coincident command is dropped
               if (start && !abort) begin
                  data_reg <= data_in;
                  c_reg    <= carry_in;
                  op_reg   <= shft_op_e'(op_in);
                  cnt_reg  <= cnt_in;
                  state    <= ST_RUN;
                  busy     <= 1'b1;
               end
            end
            ST_RUN: begin
               // abort freezes the partially shifted operand
               if (abort) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  data_reg <= shft_out;
                  c_reg    <= shft_c;
                  if (cnt_reg == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg - CNT_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Result and flags track the operand register directly
   assign result_out = data_reg;
   assign carry_out  = c_reg;
   assign sign_out   = data_reg[DATA_W-1];
   assign zero_out   = (data_reg == '0);
   assign parity_out = ~^data_reg;

endmodule

// File: tb/tb_shft_seq.sv
// Directed bench for shft_seq: vector table plus abort/reset/ignored-start sequences.
module tb_shft_seq;

   logic       clkc = 1'b0;
   logic       resetb;
   logic       start;
   logic       abort;
   logic [2:0] op_in;
   logic [2:0] cnt_in;
   logic [7:0] data_in;
   logic       carry_in;
   logic       busy;
   logic       done;
   logic [7:0] result_out;
   logic       carry_out;
   logic       sign_out;
   logic       zero_out;
   logic       parity_out;

   int pass_cnt  = 0;
   int total_cnt = 0;

   shft_seq dut (
      .clkc       (clkc),
      .resetb     (resetb),
      .start      (start),
      .abort      (abort),
      .op_in      (op_in),
      .cnt_in     (cnt_in),
      .data_in    (data_in),
      .carry_in   (carry_in),
      .busy       (busy),
      .done       (done),
      .result_out (result_out),
      .carry_out  (carry_out),
      .sign_out   (sign_out),
      .zero_out   (zero_out),
      .parity_out (parity_out)
   );

   always #5 clkc = ~clkc;

   typedef struct {
      logic [2:0] op;
      logic [2:0] cnt;
      logic [7:0] data;
      logic       cin;
      logic [7:0] res;
      logic       c;
      logic       s;
      logic       z;
      logic       p;
      int         lat;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clkc);
      #1;
   endtask

   // Present a command for one edge (E0); returns in the first RUN cycle
   task automatic issue(input logic [2:0] op, input logic [2:0] cnt,
                        input logic [7:0] d, input logic c);
      op_in    = op;
      cnt_in   = cnt;
      data_in  = d;
      carry_in = c;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   initial begin
      int   lat;
      int   ndone;
      logic got;
      logic busy_ok;
      logic [7:0] res;

      //              op    cnt   data   cin  res    c     s     z     p     lat
      vecs[0] = '{3'd1, 3'd0, 8'h81, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 2};
      vecs[1] = '{3'd0, 3'd1, 8'h80, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 3};
      vecs[2] = '{3'd2, 3'd0, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 2};
      vecs[3] = '{3'd6, 3'd7, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 9};
      vecs[4] = '{3'd7, 3'd7, 8'h81, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 9};
      vecs[5] = '{3'd5, 3'd3, 8'h00, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 5};
      vecs[6] = '{3'd3, 3'd0, 8'h01, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 2};
      vecs[7] = '{3'd4, 3'd0, 8'h81, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 2};
      vecs[8] = '{3'd0, 3'd7, 8'h55, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, 9};
      vecs[9] = '{3'd2, 3'd2, 8'h0F, 1'b0, 8'hC1, 1'b1, 1'b1, 1'b0, 1'b0, 4};

      resetb = 1'b0; start = 1'b0; abort = 1'b0;
      op_in = '0; cnt_in = '0; data_in = '0; carry_in = 1'b0;
      repeat (2) @(posedge clkc);
      #1;
      chk("rst_busy",   32'(busy),       32'd0);
      chk("rst_done",   32'(done),       32'd0);
      chk("rst_result", 32'(result_out), 32'h00);
      chk("rst_flags",  32'({carry_out, sign_out, zero_out, parity_out}), 32'b0011);
      resetb = 1'b1;
      step();

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].op, vecs[i].cnt, vecs[i].data, vecs[i].cin);
         lat = 1; got = 1'b0; busy_ok = 1'b1;
         while (!got && lat < 20) begin
            if (done) got = 1'b1;
            else begin
               if (!busy) busy_ok = 1'b0;
               step();
               lat++;
            end
         end
         chk($sformatf("v%0d_latency", i), got ? 32'(lat) : 32'd0, 32'(vecs[i].lat));
         chk($sformatf("v%0d_result", i), 32'(result_out), 32'(vecs[i].res));
         chk($sformatf("v%0d_carry", i),  32'(carry_out),  32'(vecs[i].c));
         chk($sformatf("v%0d_sign", i),   32'(sign_out),   32'(vecs[i].s));
         chk($sformatf("v%0d_zero", i),   32'(zero_out),   32'(vecs[i].z));
         chk($sformatf("v%0d_parity", i), 32'(parity_out), 32'(vecs[i].p));
         chk($sformatf("v%0d_busy_run", i), 32'(busy_ok && busy), 32'd1);
         step();
         chk($sformatf("v%0d_idle", i), 32'({busy, done}), 32'd0);
         step(); step();
         chk($sformatf("v%0d_held", i), 32'(result_out), 32'(vecs[i].res));
      end

      // start during RUN is ignored: exactly one done, original result
      issue(3'd5, 3'd3, 8'h00, 1'b0);
      ndone = 0; res = 8'h5A;
      for (int k = 0; k < 15; k++) begin
         if (k == 1) begin
            start = 1'b1; op_in = 3'd0; data_in = 8'hFF;
         end else start = 1'b0;
         if (done) begin
            ndone++;
            res = result_out;
         end
         step();
      end
      start = 1'b0;
      chk("ign_start_ndone",  32'(ndone),      32'd1);
      chk("ign_start_result", 32'(res),        32'h0F);
      chk("ign_start_final",  32'(result_out), 32'h0F);

      // abort in the 2nd RUN cycle of an 8-step SLA
      issue(3'd4, 3'd7, 8'h01, 1'b0);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         if (done) ndone++;
         step();
      end
      chk("abort_ndone",  32'(ndone),      32'd0);
      chk("abort_result", 32'(result_out), 32'h02);
      chk("abort_carry",  32'(carry_out),  32'd0);

      // abort outranks start in IDLE
      start = 1'b1; abort = 1'b1; op_in = 3'd7; data_in = 8'h55; cnt_in = 3'd0;
      step();
      start = 1'b0; abort = 1'b0;
      chk("idle_abort_busy", 32'(busy), 32'd0);
      step();
      chk("idle_abort_result", 32'(result_out), 32'h02);

      // abort during DONE does not suppress the pulse
      issue(3'd1, 3'd0, 8'h81, 1'b0);
      step();
      abort = 1'b1;
      chk("done_abort_pulse",  32'(done),       32'd1);
      chk("done_abort_result", 32'(result_out), 32'h03);
      step();
      abort = 1'b0;
      chk("done_abort_idle", 32'({busy, done}), 32'd0);

      // asynchronous reset mid-RUN
      issue(3'd6, 3'd7, 8'h80, 1'b0);
      step(); step();
      #2;
      resetb = 1'b0;
      #1;
      chk("mid_rst_busy",   32'(busy),       32'd0);
      chk("mid_rst_done",   32'(done),       32'd0);
      chk("mid_rst_result", 32'(result_out), 32'h00);
      chk("mid_rst_flags",  32'({carry_out, sign_out, zero_out, parity_out}), 32'b0011);
      step();
      resetb = 1'b1;
      step(); step();
      chk("post_rst_idle", 32'({busy, done}), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
